// File: rtl/serializador_bits.sv
// rtl/serializador_bits.sv - parallel word FIFO feeding an MSB-first serializer
// Idle line is held at 0 so the downstream detector sees a break between bursts.
module serializador_bits #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_bit,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nx;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nx;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full && !reset;
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

  // Popping at the index-0 edge keeps consecutive queued words gapless.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_nx = mem[rd_ptr];
          idx_nx   = IW'(WIDTH-1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == '0) begin
          if (!empty) begin
            pop      = 1'b1;
            shreg_nx = mem[rd_ptr];
            idx_nx   = IW'(WIDTH-1);
          end else begin
            state_nx = IDLE;
          end
        end else begin
          shreg_nx = shreg << 1;
          idx_nx   = idx - IW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      idx       <= idx_nx;
      out_valid <= (state_nx == SHIFT);
      out_bit   <= (state_nx == SHIFT) && shreg_nx[WIDTH-1];
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_serializador_bits.sv
// tb/tb_serializador_bits.sv - randomized and directed bench for serializador_bits
// Reference model schedules each accepted word's load edge and derives outputs from it.
module tb_serializador_bits;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_bit;
  logic          out_valid;
  logic [CW-1:0] fifo_count;

  serializador_bits #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Each accepted word: acceptance edge, edge it enters the shifter, data.
  int           q_acc[$];
  int           q_load[$];
  logic [W-1:0] q_data[$];
  int           last_load = -1000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < q_acc.size(); i++)
      if (q_acc[i] <= edge_n && q_load[i] > edge_n) c++;
    return c;
  endfunction

  function automatic logic [1:0] model_out();
    logic [W-1:0] w;
    for (int i = 0; i < q_load.size(); i++) begin
      if (q_load[i] <= edge_n && edge_n <= q_load[i] + W - 1) begin
        w = q_data[i];
        return {1'b1, w[W-1-(edge_n-q_load[i])]};
      end
    end
    return 2'b00;
  endfunction

  task automatic cycle(input bit rst, input bit v, input logic [W-1:0] d, output bit taken);
    bit         exp_ready;
    int         ld;
    logic [1:0] mo;
    reset    = rst;
    in_valid = v;
    in_data  = d;
    #1;
    exp_ready = !rst && (model_count() < D);
    check("in_ready", in_ready, exp_ready);
    taken = v && exp_ready;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q_acc.delete();
      q_load.delete();
      q_data.delete();
      last_load = -1000;
    end else if (taken) begin
      ld = (edge_n + 1 > last_load + W) ? edge_n + 1 : last_load + W;
      q_acc.push_back(edge_n);
      q_load.push_back(ld);
      q_data.push_back(d);
      last_load = ld;
    end
    while (q_load.size() > 0 && q_load[0] + W - 1 < edge_n) begin
      void'(q_acc.pop_front());
      void'(q_load.pop_front());
      void'(q_data.pop_front());
    end
    @(negedge clk);
    mo = model_out();
    check("out_valid", out_valid, mo[1]);
    check("out_bit", out_bit, mo[0]);
    check("fifo_count", fifo_count, model_count());
  endtask

  task automatic idle(input int k);
    bit t;
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, W'($urandom), t);
  endtask

  task automatic offer(input logic [W-1:0] d);
    bit t = 1'b0;
    for (int i = 0; i < 50 && !t; i++) cycle(1'b0, 1'b1, d, t);
    check("offer_accepted", t, 1'b1);
  endtask

  initial begin
    bit t;
    bit holding = 1'b0;
    bit v;
    bit rst;
    logic [W-1:0] hd = '0;
    int pct;

    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    cycle(1'b1, 1'b1, 8'hA5, t);
    cycle(1'b1, 1'b1, 8'hA5, t);
    check("reset_no_accept", t, 1'b0);
    idle(3);

    // single word
    offer(8'hF0);
    idle(12);

    // back-to-back
    offer(8'hAA);
    offer(8'h0F);
    idle(20);

    // fill with in_valid held high
    for (int w = 1; w <= 6; w++) offer(W'(w));
    idle(60);

    // reset during the third bit of 8'hFF
    offer(8'hFF);
    offer(8'h81);
    offer(8'h81);
    idle(1);
    cycle(1'b1, 1'b0, 8'h00, t);
    idle(20);

    // word arriving on the final bit of the previous one
    offer(8'h01);
    idle(8);
    offer(8'h80);
    idle(14);

    // randomized traffic with varying load and rare resets
    for (int c = 0; c < 900; c++) begin
      pct = (c / 100) % 3 == 0 ? 20 : ((c / 100) % 3 == 1 ? 60 : 100);
      rst = ($urandom_range(0, 199) == 0);
      if (holding) begin
        v = 1'b1;
      end else begin
        v  = ($urandom_range(1, 100) <= pct);
        hd = W'($urandom);
      end
      cycle(rst, v, hd, t);
      holding = !rst && v && !t;
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/serializador_bits.md
# serializador_bits

Upstream feeder for the serial sequence detector: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts them out MSB-first, one bit per clock, on a serial line. Consecutive queued words stream with no gap. The line is held at 0 when idle, so the downstream detector sees a break between bursts.

## Interface
- `WIDTH`, default 8: bits per word.
- `DEPTH`, default 4: FIFO depth in words (power of 2, ≥2).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  word to serialize.
- `out_bit`  out  1  serial data, MSB first; 0 when not valid.
- `out_valid`  out  1  `out_bit` carries a word bit this cycle.
- `fifo_count`  out  $clog2(DEPTH+1)  words queued, excluding the one being shifted.

## Operation
- Accept: a word is written when `in_valid && in_ready` at a rising edge. `in_ready = !full && !reset` (combinational). No write when full, even if a pop happens in the same cycle.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo DEPTH, plus an occupancy counter.
  - Push and pop in the same edge leave `fifo_count` unchanged.
- Shifter state machine, 2 states:
  - IDLE: `out_valid`=0, `out_bit`=0. If `fifo_count`>0, pop the head into the shift register, set bit index to WIDTH-1, and go to SHIFT.
  - SHIFT: `out_valid`=1, `out_bit` = shift register MSB. Each edge shifts left by 1 and decrements the index.
  - At index 0, if the FIFO is non-empty, pop the next word at that same edge and stay in SHIFT (gapless). Otherwise go to IDLE.
- `out_bit` and `out_valid` are registered outputs. `out_bit` is forced to 0 whenever `out_valid`=0.
- `in_data` values are not interpreted; any WIDTH-bit word is legal.
- `in_valid` high while `in_ready` is low: the word is ignored. The producer must hold it; no duplicate or partial write occurs.

## Timing
- Reset values (the cycle after the reset edge): state IDLE, pointers 0, `fifo_count`=0, `out_bit`=0, `out_valid`=0. `in_ready`=0 while `reset` is high and 1 after release.
- Reset mid-word or with a non-empty FIFO:
  - The current word is aborted and all queued words are discarded.
  - The serial line goes to 0 on the next cycle.
- Latency: word accepted at edge k → FIFO head after k → loaded at edge k+1 → MSB on `out_bit` in the cycle after k+1. Bit i (MSB=WIDTH-1) appears in the cycle after edge k+1+(WIDTH-1-i).
- Throughput: one word per WIDTH cycles sustained, with `out_valid` continuously high.
- Full boundary: `in_ready` falls in the cycle after the edge that makes `fifo_count`=DEPTH. It rises again in the cycle after the next pop.
- Empty boundary: a word accepted while the shifter is emitting its last bit (index 0) and the FIFO is empty is not loaded at that edge. It produces a 1-cycle idle gap (`out_valid`=0, `out_bit`=0) before its MSB.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_bit`=0, `fifo_count`=0; no word accepted. After release, `in_ready`=1.
- Single word: push 8'hF0 at edge 0 → on the cycles after edges 1..8, `out_bit` = 1,1,1,1,0,0,0,0 with `out_valid`=1. Then `out_valid`=0 and `out_bit`=0.
- Back-to-back: push 8'hAA then 8'h0F on consecutive edges → 16 consecutive valid bits 1010101000001111 with no gap. `fifo_count` peaks at 1.
- Fill, with `in_valid` held high and words 8'h01..8'h06 offered in order (words 1-5 accepted at edges 0-4):
  - `fifo_count`=4 after edge 4, and `in_ready`=0 from then until edge 9.
  - 8'h06 is accepted only after `in_ready` returns to 1.
  - Output order is 01,02,03,04,05,06 with no loss or duplicate.
- Reset mid-operation: push 8'hFF, 8'h81, 8'h81, then assert `reset` during the 3rd bit of 8'hFF:
  - Next cycle: `out_valid`=0, `out_bit`=0, `fifo_count`=0.
  - No further 1s appear, so the detector never sees 4 consecutive 1s from this burst.
- Last-bit gap: push 8'h01 and, during its final bit, push 8'h80 → exactly one idle cycle, then 1 followed by seven 0s.
